// File: rtl/mirq_trap_ctrl_if.sv
// Bundle of interrupt inputs, CSR views and the core-side trap handshake
// for the machine-level interrupt trap controller.
interface mirq_trap_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 irq_msip;
    logic                 irq_mtip;
    logic                 irq_meip;
    logic [31:0]          mie;
    logic                 mstatus_mie;
    logic                 trap_ack;
    logic                 mret;
    logic [31:0]          mip;
    logic                 trap_req;
    logic [3:0]           trap_cause;
    logic                 in_handler;
    logic [CNT_WIDTH-1:0] trap_count;

    // Interrupt sources, CSRs and core pipeline side.
    modport master (
        output irq_msip, irq_mtip, irq_meip, mie, mstatus_mie, trap_ack, mret,
        input  mip, trap_req, trap_cause, in_handler, trap_count
    );

    // Trap controller side.
    modport slave (
        input  irq_msip, irq_mtip, irq_meip, mie, mstatus_mie, trap_ack, mret,
        output mip, trap_req, trap_cause, in_handler, trap_count
    );
endinterface

// File: rtl/mirq_trap_ctrl.sv
// Machine-level interrupt pending/arbitration stage behind the CLINT.
// Registers msip/mtip/meip, forms mip, masks with mie and mstatus.MIE,
// arbitrates 11 > 3 > 7 and holds a trap request until the core acks it
// or the latched source goes away. Residency is tracked until mret.
module mirq_trap_ctrl #(
    parameter int MEIP_SYNC_STAGES = 2,
    parameter int CNT_WIDTH        = 32
) (
    input  logic             clk,
    input  logic             reset,
    mirq_trap_ctrl_if.slave  bus
);
    // A setting of 0 still keeps one plain register, like msip/mtip.
    localparam int MEIP_FLOPS = (MEIP_SYNC_STAGES == 0) ? 1 : MEIP_SYNC_STAGES;

    localparam logic [31:0] IRQ_MASK   = 32'h0000_0888;
    localparam logic [3:0]  CAUSE_MSIP = 4'd3;
    localparam logic [3:0]  CAUSE_MTIP = 4'd7;
    localparam logic [3:0]  CAUSE_MEIP = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HANDLER = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cause_q, cause_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;

    logic                   msip_q;
    logic                   mtip_q;
    logic [MEIP_FLOPS-1:0]  meip_q;

    logic [31:0]            mip_w;
    logic [31:0]            pend;
    logic                   fire;
    logic [3:0]             win_cause;
    logic                   cause_pend;

    // Input registers; meip goes through a synchroniser chain since it is asynchronous.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            msip_q <= 1'b0;
            mtip_q <= 1'b0;
            meip_q <= '0;
        end else begin
            msip_q    <= bus.irq_msip;
            mtip_q    <= bus.irq_mtip;
            meip_q[0] <= bus.irq_meip;
            for (int i = 1; i < MEIP_FLOPS; i++) begin
                meip_q[i] <= meip_q[i-1];
            end
        end
    end

    // Pending view, enabled set and fixed-priority winner (11 > 3 > 7).
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        mip_w      = '0;
        mip_w[3]   = msip_q;
        mip_w[7]   = mtip_q;
        mip_w[11]  = meip_q[MEIP_FLOPS-1];
        pend       = mip_w & bus.mie & IRQ_MASK;
        fire       = (|pend) & bus.mstatus_mie;
        win_cause  = CAUSE_MTIP;
        if (pend[11]) begin
            win_cause = CAUSE_MEIP;
        end else if (pend[3]) begin
            win_cause = CAUSE_MSIP;
        end
        cause_pend = 1'b0;
        case (cause_q)
            CAUSE_MSIP: cause_pend = pend[3];
            CAUSE_MTIP: cause_pend = pend[7];
            CAUSE_MEIP: cause_pend = pend[11];
            default:    cause_pend = 1'b0;
        endcase
    end

    // State, latched cause and taken-trap counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cause_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: request on fire, ack beats withdrawal, mret ends residency.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    state_d = ST_REQ;
                    cause_d = win_cause;
                end
            end
            ST_REQ: begin
                if (bus.trap_ack) begin
                    state_d = ST_HANDLER;
                    count_d = count_q + CNT_WIDTH'(1);
                end else if (!cause_pend || !bus.mstatus_mie) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HANDLER: begin
                if (bus.mret) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mip        = mip_w;
    assign bus.trap_req   = (state_q == ST_REQ);
    assign bus.in_handler = (state_q == ST_HANDLER);
    assign bus.trap_cause = cause_q;
    assign bus.trap_count = count_q;

endmodule

// File: tb/tb_mirq_trap_ctrl.sv
// Self-checking bench for mirq_trap_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_mirq_trap_ctrl;
    localparam int SYNC = 2;
    localparam int LAT  = (SYNC == 0) ? 1 : SYNC;
    localparam int CW   = 4;

    logic clk;
    logic reset;

    int n_total;
    int n_bad;

    mirq_trap_ctrl_if #(.CNT_WIDTH(CW)) bus ();

    mirq_trap_ctrl #(
        .MEIP_SYNC_STAGES(SYNC),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: registered sources, meip latency history and trap progress.
    logic          m_msip;
    logic          m_mtip;
    logic          meip_hist[$];
    logic          m_req;
    logic          m_hand;
    logic [3:0]    m_cause;
    logic [CW-1:0] m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_mip();
        logic [31:0] v;
        v     = '0;
        v[3]  = m_msip;
        v[7]  = m_mtip;
        v[11] = (meip_hist.size() > 0) ? meip_hist[0] : 1'b0;
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [31:0] pend;
        logic        fire;
        logic [3:0]  win;
        pend = model_mip() & bus.mie & 32'h0000_0888;
        fire = (pend != 0) && bus.mstatus_mie;
        if (pend[11])     win = 4'd11;
        else if (pend[3]) win = 4'd3;
        else              win = 4'd7;
        if (reset) begin
            m_req     = 1'b0;
            m_hand    = 1'b0;
            m_cause   = '0;
            m_count   = '0;
            m_msip    = 1'b0;
            m_mtip    = 1'b0;
            meip_hist = {};
            for (int i = 0; i < LAT; i++) meip_hist.push_back(1'b0);
        end else begin
            if (m_hand) begin
                if (bus.mret) m_hand = 1'b0;
            end else if (m_req) begin
                if (bus.trap_ack) begin
                    m_req   = 1'b0;
                    m_hand  = 1'b1;
                    m_count = m_count + 1'b1;
                end else if (!pend[m_cause] || !bus.mstatus_mie) begin
                    m_req = 1'b0;
                end
            end else if (fire) begin
                m_req   = 1'b1;
                m_cause = win;
            end
            m_msip = bus.irq_msip;
            m_mtip = bus.irq_mtip;
            meip_hist.push_back(bus.irq_meip);
            void'(meip_hist.pop_front());
        end
    endtask

    task automatic compare();
        check("mip",        bus.mip,        model_mip());
        check("trap_req",   32'(bus.trap_req),   32'(m_req));
        check("trap_cause", 32'(bus.trap_cause), 32'(m_cause));
        check("in_handler", 32'(bus.in_handler), 32'(m_hand));
        check("trap_count", 32'(bus.trap_count), 32'(m_count));
    endtask

    // One clock: model the coming edge, let the DUT take it, compare on the falling edge.
    task automatic step();
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle_inputs();
        bus.irq_msip    = 1'b0;
        bus.irq_mtip    = 1'b0;
        bus.irq_meip    = 1'b0;
        bus.mie         = '0;
        bus.mstatus_mie = 1'b0;
        bus.trap_ack    = 1'b0;
        bus.mret        = 1'b0;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        m_msip    = 1'b0;
        m_mtip    = 1'b0;
        m_req     = 1'b0;
        m_hand    = 1'b0;
        m_cause   = '0;
        m_count   = '0;
        meip_hist = {};
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        check("rst_req", 32'(bus.trap_req), 32'd0);

        // Timer interrupt: request two cycles after the input, cause 7, then ack.
        reset           = 1'b0;
        bus.irq_mtip    = 1'b1;
        bus.mie         = 32'h0000_0080;
        bus.mstatus_mie = 1'b1;
        step();
        check("t1_req_c1", 32'(bus.trap_req), 32'd0);
        step();
        check("t1_req_c2", 32'(bus.trap_req), 32'd1);
        check("t1_cause",  32'(bus.trap_cause), 32'd7);
        bus.trap_ack = 1'b1;
        step();
        bus.trap_ack = 1'b0;
        check("t1_inh",   32'(bus.in_handler), 32'd1);
        check("t1_count", 32'(bus.trap_count), 32'd1);

        // In handler with source still pending: no request until mret.
        step();
        step();
        check("t5_noreq", 32'(bus.trap_req), 32'd0);
        bus.mret = 1'b1;
        step();
        bus.mret = 1'b0;
        step();
        check("t5_b2b", 32'(bus.trap_req), 32'd1);

        // Withdrawal: drop mtip while requesting, no count.
        bus.irq_mtip = 1'b0;
        step();
        check("t3_held", 32'(bus.trap_req), 32'd1);
        step();
        check("t3_wdrw",  32'(bus.trap_req), 32'd0);
        check("t3_count", 32'(bus.trap_count), 32'd1);

        // Ack and withdrawal (global disable) together: ack wins.
        bus.irq_mtip = 1'b1;
        step();
        step();
        bus.trap_ack    = 1'b1;
        bus.mstatus_mie = 1'b0;
        step();
        bus.trap_ack    = 1'b0;
        bus.mstatus_mie = 1'b1;
        check("t4_inh",   32'(bus.in_handler), 32'd1);
        check("t4_count", 32'(bus.trap_count), 32'd2);

        // Reset during HANDLER, then during REQ.
        reset = 1'b1;
        step();
        check("t6_rst_h", 32'(bus.trap_count), 32'd0);
        reset = 1'b0;
        step();
        step();
        check("t6_req", 32'(bus.trap_req), 32'd1);
        reset = 1'b1;
        step();
        check("t6_rst_r", 32'(bus.trap_req), 32'd0);
        reset = 1'b0;

        // Spurious mret/ack in IDLE change nothing.
        bus.irq_mtip = 1'b0;
        bus.mret     = 1'b1;
        bus.trap_ack = 1'b1;
        step();
        step();
        bus.mret     = 1'b0;
        bus.trap_ack = 1'b0;
        check("sp_inh",   32'(bus.in_handler), 32'd0);
        check("sp_count", 32'(bus.trap_count), 32'd0);

        // All three sources: msip wins before meip is synced, meip wins next.
        bus.irq_msip = 1'b1;
        bus.irq_mtip = 1'b1;
        bus.irq_meip = 1'b1;
        bus.mie      = 32'h0000_0888;
        step();
        step();
        check("t2_cause_a", 32'(bus.trap_cause), 32'd3);
        bus.trap_ack = 1'b1;
        step();
        bus.trap_ack = 1'b0;
        bus.irq_msip = 1'b0;
        bus.mret     = 1'b1;
        step();
        bus.mret = 1'b0;
        step();
        check("t2_cause_b", 32'(bus.trap_cause), 32'd11);

        // Counter wrap: 2^CW acknowledged traps from reset.
        idle_inputs();
        reset = 1'b1;
        step();
        reset           = 1'b0;
        bus.irq_mtip    = 1'b1;
        bus.mie         = 32'h0000_0080;
        bus.mstatus_mie = 1'b1;
        step();
        for (int i = 0; i < (1 << CW); i++) begin
            step();
            bus.trap_ack = 1'b1;
            step();
            bus.trap_ack = 1'b0;
            if (i == (1 << CW) - 2) check("wrap_max", 32'(bus.trap_count), 32'((1 << CW) - 1));
            bus.mret = 1'b1;
            step();
            bus.mret = 1'b0;
        end
        check("wrap_zero", 32'(bus.trap_count), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0)  bus.irq_msip = ~bus.irq_msip;
            if ($urandom_range(0, 7) == 0)  bus.irq_mtip = ~bus.irq_mtip;
            if ($urandom_range(0, 5) == 0)  bus.irq_meip = ~bus.irq_meip;
            if ($urandom_range(0, 19) == 0) bus.mie = $urandom;
            bus.mstatus_mie = ($urandom_range(0, 9) != 0);
            bus.trap_ack    = ($urandom_range(0, 3) == 0);
            bus.mret        = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
